// File: rtl/fx2_pkg.sv
// Shared constants and FSM state type for the FX2 LED command controller.
package fx2_pkg;

    // FIFOADR encodings for the two FX2 endpoints this block talks to.
    localparam logic [1:0] FIFO2_ADR = 2'b00;
    localparam logic [1:0] FIFO4_ADR = 2'b10;

    // Command opcodes; duty commands occupy OP_DUTY_BASE + channel.
    localparam logic [7:0] OP_DUTY_BASE = 8'h00;
    localparam logic [7:0] OP_DIV       = 8'h10;
    localparam logic [7:0] OP_READBACK  = 8'h20;

    // First byte of every status packet.
    localparam logic [7:0] STATUS_MAGIC = 8'hA5;

    // Command / status transaction sequencer states.
    typedef enum logic [2:0] {
        RD_OP,
        RD_VAL,
        EXEC,
        TURN_W,
        WR0,
        WR1,
        PKT,
        TURN_R
    } fx2_state_t;

endpackage

// File: rtl/fx2_pwm_channel.sv
// One PWM LED channel: holds its duty value and compares it against the
// shared free-running PWM counter.
module fx2_pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                FX2_CLK,
    input  logic                FX2_RST,
    input  logic                duty_we,
    input  logic [PWM_BITS-1:0] duty_in,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    logic [PWM_BITS-1:0] duty;

    // Duty register, loaded by the command executor.
    // NOTE: duty is a few plain flops, not a RAM, so it takes the async reset like all other state.
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) duty <= '0;
        else if (duty_we) duty <= duty_in;
    end

    // Registered compare gives a glitch-free LED output one cycle behind pwm_cnt.
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) led <= 1'b0;
        else led <= (pwm_cnt < duty);
    end

endmodule

// File: rtl/fx2_led_cmd_ctrl.sv
// FX2 LED command controller: reads 2-byte commands from FIFO2, drives PWM
// LEDs and a divided clock tap, and answers readback with a status packet on FIFO4.
module fx2_led_cmd_ctrl
    import fx2_pkg::*;
#(
    parameter int NUM_LEDS = 2,
    parameter int PWM_BITS = 8,
    parameter int DIV_BASE = 20
) (
    input  logic                FX2_CLK,
    input  logic                FX2_RST,
    input  logic [7:0]          FIFO_DATAIN,
    input  logic                FIFO2_data_available,
    input  logic                FIFO4_ready_to_accept_data,
    output logic                FIFO_RD,
    output logic                FIFO_WR,
    output logic [7:0]          FIFO_DATAOUT,
    output logic                FIFO_DATAIN_OE,
    output logic                FIFO_DATAOUT_OE,
    output logic                FIFO_PKTEND,
    output logic [1:0]          FIFO_FIFOADR,
    output logic [NUM_LEDS-1:0] LED,
    output logic                gpio_out
);

    localparam int CNT_W = DIV_BASE + 8;

    fx2_state_t          state, state_next;
    logic [7:0]          op_q, val_q, cmd_cnt;
    logic [2:0]          div_sel;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [CNT_W-1:0]    cnt;
    logic [7:0]          cnt_top;
    logic                duty_op;
    logic [NUM_LEDS-1:0] duty_we;

    // Handshake strobes are gated by reset so nothing is requested while held in reset.
    assign FIFO_RD = !FX2_RST && (state == RD_OP || state == RD_VAL)
                     && FIFO2_data_available && (FIFO_FIFOADR == FIFO2_ADR);
    assign FIFO_WR = !FX2_RST && (state == WR0 || state == WR1) && FIFO4_ready_to_accept_data;
    assign FIFO_PKTEND = !FX2_RST && (state == PKT) && FIFO4_ready_to_accept_data;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) state <= RD_OP;
        else state <= state_next;
    end

    // Next-state logic: reads and writes advance only on completed transfers.
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            RD_OP:   if (FIFO_RD) state_next = RD_VAL;
            RD_VAL:  if (FIFO_RD) state_next = EXEC;
            EXEC:    state_next = (op_q == OP_READBACK) ? TURN_W : RD_OP;
            TURN_W:  state_next = WR0;
            WR0:     if (FIFO_WR) state_next = WR1;
            WR1:     if (FIFO_WR) state_next = PKT;
            PKT:     if (FIFO_PKTEND) state_next = TURN_R;
            TURN_R:  state_next = RD_OP;
            default: state_next = RD_OP;
        endcase
    end

    // Status byte presented on the bus during the two write states.
    always_comb begin
        FIFO_DATAOUT = 8'h00;
        case (state)
            WR0:     FIFO_DATAOUT = STATUS_MAGIC;
            WR1:     FIFO_DATAOUT = cmd_cnt;
            default: FIFO_DATAOUT = 8'h00;
        endcase
    end

    // Command capture, execution and bus turnaround registers.
    // DATAIN_OE drops at the same edge DATAOUT_OE rises, and rises one cycle
    // after DATAOUT_OE drops, so the two enables never overlap.
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) begin
            op_q            <= 8'h00;
            val_q           <= 8'h00;
            cmd_cnt         <= 8'h00;
            div_sel         <= 3'd0;
            FIFO_FIFOADR    <= FIFO2_ADR;
            FIFO_DATAIN_OE  <= 1'b1;
            FIFO_DATAOUT_OE <= 1'b0;
        end else begin
            if (state == RD_OP && FIFO_RD) op_q <= FIFO_DATAIN;
            if (state == RD_VAL && FIFO_RD) val_q <= FIFO_DATAIN;
            if (state == EXEC) begin
                cmd_cnt <= cmd_cnt + 8'd1;
                if (op_q == OP_DIV) div_sel <= val_q[2:0];
                if (op_q == OP_READBACK) begin
                    FIFO_FIFOADR    <= FIFO4_ADR;
                    FIFO_DATAIN_OE  <= 1'b0;
                    FIFO_DATAOUT_OE <= 1'b1;
                end
            end
            if (FIFO_PKTEND) begin
                FIFO_DATAOUT_OE <= 1'b0;
                FIFO_FIFOADR    <= FIFO2_ADR;
            end
            if (state == TURN_R) FIFO_DATAIN_OE <= 1'b1;
        end
    end

    // Free-running PWM and divider counters.
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) begin
            pwm_cnt <= '0;
            cnt     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            cnt     <= cnt + CNT_W'(1);
        end
    end

    assign cnt_top = cnt[DIV_BASE +: 8];

    // Registered divider tap selected by div_sel.
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) gpio_out <= 1'b0;
        else gpio_out <= cnt_top[div_sel];
    end

    // Duty opcodes 0x00..0x0F; channels beyond NUM_LEDS get no write enable.
    assign duty_op = (op_q[7:4] == OP_DUTY_BASE[7:4]);

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        assign duty_we[i] = (state == EXEC) && duty_op && (op_q[3:0] == 4'(i));

        fx2_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .FX2_CLK(FX2_CLK),
            .FX2_RST(FX2_RST),
            .duty_we(duty_we[i]),
            .duty_in(PWM_BITS'(val_q)),
            .pwm_cnt(pwm_cnt),
            .led    (LED[i])
        );
    end

endmodule

// File: tb/tb_fx2_led_cmd_ctrl.sv
// Directed testbench for fx2_led_cmd_ctrl (NUM_LEDS=2, PWM_BITS=8, DIV_BASE=2).
module tb_fx2_led_cmd_ctrl;
    import fx2_pkg::*;

    localparam int NUM_LEDS = 2;
    localparam int PWM_BITS = 8;
    localparam int DIV_BASE = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          din = 8'h00;
    logic                avail = 1'b0;
    logic                ready = 1'b0;
    logic                fifo_rd, fifo_wr, datain_oe, dataout_oe, pktend, gpio;
    logic [7:0]          dataout;
    logic [1:0]          fifoadr;
    logic [NUM_LEDS-1:0] led;

    int total = 0;
    int bad   = 0;

    logic [7:0] wq[$];
    int pkt_cnt = 0;
    int oe_both = 0;
    int wr_bad  = 0;

    fx2_led_cmd_ctrl #(
        .NUM_LEDS(NUM_LEDS),
        .PWM_BITS(PWM_BITS),
        .DIV_BASE(DIV_BASE)
    ) dut (
        .FX2_CLK                   (clk),
        .FX2_RST                   (rst),
        .FIFO_DATAIN               (din),
        .FIFO2_data_available      (avail),
        .FIFO4_ready_to_accept_data(ready),
        .FIFO_RD                   (fifo_rd),
        .FIFO_WR                   (fifo_wr),
        .FIFO_DATAOUT              (dataout),
        .FIFO_DATAIN_OE            (datain_oe),
        .FIFO_DATAOUT_OE           (dataout_oe),
        .FIFO_PKTEND               (pktend),
        .FIFO_FIFOADR              (fifoadr),
        .LED                       (led),
        .gpio_out                  (gpio)
    );

    always #5 clk = ~clk;

    // FIFO4 side: record written bytes, packet ends and protocol violations.
    always @(posedge clk) begin
        if (fifo_wr && ready) wq.push_back(dataout);
        if (fifo_wr && !ready) wr_bad++;
        if (pktend) pkt_cnt++;
        if (datain_oe && dataout_oe) oe_both++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        din = b;
        avail = 1'b1;
        n = 0;
        #1;
        while (!fifo_rd && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL send_byte %02h: FIFO_RD got %0b want 1", b, fifo_rd);
        end
        @(negedge clk);
        avail = 1'b0;
    endtask

    task automatic wait_state(input fx2_state_t s, input int lim);
        int n;
        n = 0;
        while (dut.state != s && n < lim) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (dut.state != s) begin
            bad++;
            $display("FAIL wait_state: state got %0d want %0d", dut.state, s);
        end
    endtask

    task automatic measure_leds(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            c0 += int'(led[0]);
            c1 += int'(led[1]);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total += 9;
        if (fifo_rd !== 1'b0)    begin bad++; $display("FAIL rst_rd: got %0b want 0", fifo_rd); end
        if (fifo_wr !== 1'b0)    begin bad++; $display("FAIL rst_wr: got %0b want 0", fifo_wr); end
        if (pktend !== 1'b0)     begin bad++; $display("FAIL rst_pktend: got %0b want 0", pktend); end
        if (dataout !== 8'h00)   begin bad++; $display("FAIL rst_dataout: got %02h want 00", dataout); end
        if (dataout_oe !== 1'b0) begin bad++; $display("FAIL rst_dataout_oe: got %0b want 0", dataout_oe); end
        if (datain_oe !== 1'b1)  begin bad++; $display("FAIL rst_datain_oe: got %0b want 1", datain_oe); end
        if (fifoadr !== 2'b00)   begin bad++; $display("FAIL rst_fifoadr: got %02b want 00", fifoadr); end
        if (led !== 2'b00)       begin bad++; $display("FAIL rst_led: got %02b want 00", led); end
        if (gpio !== 1'b0)       begin bad++; $display("FAIL rst_gpio: got %0b want 0", gpio); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wr0;
        int p0;
        ready = 1'b0;
        send_byte(8'h20);
        send_byte(8'h00);
        wait_state(WR0, 20);
        #1;
        total += 4;
        if (fifoadr !== 2'b10)   begin bad++; $display("FAIL wr0_fifoadr: got %02b want 10", fifoadr); end
        if (dataout_oe !== 1'b1) begin bad++; $display("FAIL wr0_dataout_oe: got %0b want 1", dataout_oe); end
        if (datain_oe !== 1'b0)  begin bad++; $display("FAIL wr0_datain_oe: got %0b want 0", datain_oe); end
        if (dataout !== 8'hA5)   begin bad++; $display("FAIL wr0_dataout: got %02h want a5", dataout); end
        p0 = pkt_cnt;
        rst = 1'b1;
        #1;
        total += 6;
        if (dut.state != RD_OP)  begin bad++; $display("FAIL mid_rst_state: got %0d want %0d", dut.state, RD_OP); end
        if (fifoadr !== 2'b00)   begin bad++; $display("FAIL mid_rst_fifoadr: got %02b want 00", fifoadr); end
        if (datain_oe !== 1'b1)  begin bad++; $display("FAIL mid_rst_datain_oe: got %0b want 1", datain_oe); end
        if (dataout_oe !== 1'b0) begin bad++; $display("FAIL mid_rst_dataout_oe: got %0b want 0", dataout_oe); end
        if (led !== 2'b00)       begin bad++; $display("FAIL mid_rst_led: got %02b want 00", led); end
        if (fifo_wr !== 1'b0)    begin bad++; $display("FAIL mid_rst_wr: got %0b want 0", fifo_wr); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (pkt_cnt != p0) begin bad++; $display("FAIL mid_rst_pktend: pulses got %0d want 0", pkt_cnt - p0); end
    endtask

    task automatic test_readback_stall;
        int n0, p0;
        n0 = wq.size();
        p0 = pkt_cnt;
        ready = 1'b0;
        send_byte(8'h20);
        send_byte(8'h00);
        wait_state(WR0, 20);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #1;
        total += 2;
        if (dut.state != WR1)  begin bad++; $display("FAIL stall_state: got %0d want %0d", dut.state, WR1); end
        if (dataout !== 8'h01) begin bad++; $display("FAIL stall_dataout: got %02h want 01", dataout); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (fifo_wr !== 1'b0 || dut.state != WR1) begin
                bad++;
                $display("FAIL stall_hold[%0d]: wr=%0b state=%0d want wr=0 state=%0d", i, fifo_wr, dut.state, WR1);
            end
        end
        ready = 1'b1;
        wait_state(RD_OP, 20);
        #1;
        total += 5;
        if (wq.size() - n0 != 2) begin
            bad++;
            $display("FAIL stall_nbytes: got %0d want 2", wq.size() - n0);
        end else begin
            if (wq[n0] !== 8'hA5)   begin bad++; $display("FAIL stall_byte0: got %02h want a5", wq[n0]); end
            if (wq[n0+1] !== 8'h01) begin bad++; $display("FAIL stall_byte1: got %02h want 01", wq[n0+1]); end
        end
        if (pkt_cnt - p0 != 1)  begin bad++; $display("FAIL stall_pktend: got %0d want 1", pkt_cnt - p0); end
        if (datain_oe !== 1'b1) begin bad++; $display("FAIL stall_datain_oe: got %0b want 1", datain_oe); end
        total += 2;
        if (oe_both != 0) begin bad++; $display("FAIL oe_overlap: cycles got %0d want 0", oe_both); end
        if (wr_bad != 0)  begin bad++; $display("FAIL wr_not_ready: cycles got %0d want 0", wr_bad); end
    endtask

    task automatic test_led_duty;
        int c0, c1;
        send_byte(8'h01);
        send_byte(8'h80);
        repeat (3) @(negedge clk);
        measure_leds(c0, c1);
        total += 2;
        if (c1 != 128) begin bad++; $display("FAIL duty_led1: high got %0d want 128", c1); end
        if (c0 != 0)   begin bad++; $display("FAIL duty_led0: high got %0d want 0", c0); end
    endtask

    task automatic test_bad_led;
        int c0, c1, n0, p0;
        send_byte(8'h05);
        send_byte(8'hFF);
        repeat (3) @(negedge clk);
        measure_leds(c0, c1);
        total += 2;
        if (c1 != 128) begin bad++; $display("FAIL badled_led1: high got %0d want 128", c1); end
        if (c0 != 0)   begin bad++; $display("FAIL badled_led0: high got %0d want 0", c0); end
        n0 = wq.size();
        p0 = pkt_cnt;
        ready = 1'b1;
        send_byte(8'h20);
        send_byte(8'h00);
        repeat (12) @(negedge clk);
        total += 3;
        if (wq.size() - n0 != 2) begin
            bad++;
            $display("FAIL badled_nbytes: got %0d want 2", wq.size() - n0);
        end else begin
            if (wq[n0] !== 8'hA5)   begin bad++; $display("FAIL badled_byte0: got %02h want a5", wq[n0]); end
            if (wq[n0+1] !== 8'h04) begin bad++; $display("FAIL badled_cmdcnt: got %02h want 04", wq[n0+1]); end
        end
        if (pkt_cnt - p0 != 1) begin bad++; $display("FAIL badled_pktend: got %0d want 1", pkt_cnt - p0); end
    endtask

    task automatic test_div;
        logic prev;
        int last, toggles, gap_err;
        send_byte(8'h10);
        send_byte(8'h03);
        repeat (3) @(negedge clk);
        prev = gpio;
        last = -1;
        toggles = 0;
        gap_err = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (gpio !== prev) begin
                if (last >= 0 && i - last != 32) gap_err++;
                last = i;
                toggles++;
                prev = gpio;
            end
        end
        total += 2;
        if (toggles < 8)  begin bad++; $display("FAIL div_toggles: got %0d want >=8", toggles); end
        if (gap_err != 0) begin bad++; $display("FAIL div_period: bad gaps got %0d want 0", gap_err); end
    endtask

    task automatic test_rd_gap;
        int c0, c1;
        send_byte(8'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (fifo_rd !== 1'b0 || dut.state != RD_VAL || led[0] !== 1'b0) begin
                bad++;
                $display("FAIL gap_hold[%0d]: rd=%0b state=%0d led0=%0b want 0/%0d/0", i, fifo_rd, dut.state, led[0], RD_VAL);
            end
        end
        @(negedge clk);
        send_byte(8'h40);
        repeat (3) @(negedge clk);
        measure_leds(c0, c1);
        total += 2;
        if (c0 != 64)  begin bad++; $display("FAIL gap_led0: high got %0d want 64", c0); end
        if (c1 != 128) begin bad++; $display("FAIL gap_led1: high got %0d want 128", c1); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wr0();
        test_readback_stall();
        test_led_duty();
        test_bad_led();
        test_div();
        test_rd_gap();
        total++;
        if (oe_both != 0) begin bad++; $display("FAIL oe_overlap_final: cycles got %0d want 0", oe_both); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
